// File: rtl/uart_frame_parser.sv
// uart_frame_parser: turns the UART RX byte stream into command frames.
// A frame is START, N_OPS operand bytes, an opcode byte and, optionally, an
// XOR checksum byte. The parser detects inter-byte timeouts and hands each
// decoded command to the core over a valid/ready output.
//
// Handshake: cmd_valid is high in HOLD and stays high until a cycle where
// cmd_valid && cmd_ready. That cycle completes the transfer and cmd_valid
// drops on the next cycle. cmd_operands and cmd_opcode change only at a
// commit, so they hold steady while cmd_valid is high and after the transfer.
module uart_frame_parser #(
  parameter logic [7:0] START_BYTE  = 8'hFE,
  parameter int         N_OPS       = 2,
  parameter int         OPCODE_W    = 3,
  parameter bit         CHECKSUM_EN = 1'b1,
  parameter int         TIMEOUT_CYC = 100000,
  parameter int         TO_W        = 17
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [8*N_OPS-1:0]    cmd_operands,
  output logic [OPCODE_W-1:0]   cmd_opcode,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  err_checksum,
  output logic                  err_timeout,
  output logic                  err_overrun,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OPERANDS = 3'd1,
    S_OPCODE   = 3'd2,
    S_CHECK    = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  localparam int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OPS - 1);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  // The timeout fires on the TIMEOUT_CYC-th consecutive quiet cycle, which
  // is the cycle the counter would step up to TIMEOUT_CYC.
  localparam int TO_LAST_I = TO_EN ? (TIMEOUT_CYC - 1) : 0;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx;
  logic [8*N_OPS-1:0]   sh_ops;
  logic [7:0]           sh_opc;
  logic [7:0]           xor_acc;
  logic [TO_W-1:0]      to_cnt;

  logic in_frame, expired;
  logic start, store_op, store_opc, commit;
  logic ck_err, to_err, ov_err;
  logic [OPCODE_W-1:0]  commit_opc;

  assign in_frame  = (state == S_OPERANDS) || (state == S_OPCODE) || (state == S_CHECK);
  assign expired   = TO_EN && in_frame && !rx_valid && (to_cnt == TO_LAST);
  assign cmd_valid = (state == S_HOLD);
  assign dbg_state = state;

  // Without a checksum byte the commit happens on the opcode byte itself,
  // so the opcode must be taken straight from rx_data.
  assign commit_opc = (state == S_OPCODE) ? rx_data[OPCODE_W-1:0] : sh_opc[OPCODE_W-1:0];

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    store_op   = 1'b0;
    store_opc  = 1'b0;
    commit     = 1'b0;
    ck_err     = 1'b0;
    to_err     = 1'b0;
    ov_err     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == START_BYTE) begin
          start      = 1'b1;
          state_next = S_OPERANDS;
        end
      end
      S_OPERANDS: begin
        if (rx_valid) begin
          store_op = 1'b1;
          if (idx == IDX_LAST) state_next = S_OPCODE;
        end else if (expired) begin
          to_err     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_OPCODE: begin
        if (rx_valid) begin
          store_opc = 1'b1;
          if (CHECKSUM_EN) begin
            state_next = S_CHECK;
          end else begin
            commit     = 1'b1;
            state_next = S_HOLD;
          end
        end else if (expired) begin
          to_err     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_data == xor_acc) begin
            commit     = 1'b1;
            state_next = S_HOLD;
          end else begin
            ck_err     = 1'b1;
            state_next = S_IDLE;
          end
        end else if (expired) begin
          to_err     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cmd_ready) begin
          // The transfer frees the parser this cycle, so a START arriving
          // now opens the next frame without loss.
          state_next = S_IDLE;
          if (rx_valid && rx_data == START_BYTE) begin
            start      = 1'b1;
            state_next = S_OPERANDS;
          end
        end else if (rx_valid) begin
          ov_err = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shadow registers, byte index and running checksum for the frame in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx     <= '0;
      sh_ops  <= '0;
      sh_opc  <= '0;
      xor_acc <= '0;
    end else begin
      if (start) begin
        idx     <= '0;
        xor_acc <= '0;
      end
      if (store_op) begin
        sh_ops[{idx, 3'b000} +: 8] <= rx_data;
        idx     <= idx + 1'b1;
        xor_acc <= xor_acc ^ rx_data;
      end
      if (store_opc) begin
        sh_opc  <= rx_data;
        xor_acc <= xor_acc ^ rx_data;
      end
    end
  end

  // Command outputs, loaded only when a frame commits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_operands <= '0;
      cmd_opcode   <= '0;
    end else if (commit) begin
      cmd_operands <= (state == S_OPCODE) ? sh_ops : sh_ops;
      cmd_opcode   <= commit_opc;
    end
  end

  // Inter-byte idle counter: cleared by a frame start or any byte inside a
  // frame, counts quiet cycles inside a frame, frozen in IDLE and HOLD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                       to_cnt <= '0;
    else if (start || (in_frame && rx_valid)) to_cnt <= '0;
    else if (TO_EN && in_frame)         to_cnt <= to_cnt + 1'b1;
  end

  // Registered single-cycle error pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      err_checksum <= ck_err;
      err_timeout  <= to_err;
      err_overrun  <= ov_err;
    end
  end

endmodule
